sram_port_ctrl: RTL

- Initiator/controller for the single-port fakeram45 wrapper macros (CLK/ADR/D/Q/WE style, 1-cycle read, CE tied high).
- Fills the whole array with a constant after reset.
- After the fill, accepts valid/ready read/write requests and drives the RAM pins from registers.
- Captures Q into a credit-managed response FIFO so that backpressure never loses read data.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_port_ctrl_if.sv | 28 ++
 rtl/sram_rsp_fifo.sv | 57 +++++
 rtl/sram_port_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the fakeram45 port controller: FSM state and the debug view
// exported by the controller.
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        state_e state;
        logic   rsp_full;
        logic   rsp_empty;
    } ctrl_dbg_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response bus of the fakeram45 port controller.
interface sram_port_ctrl_if #(
    parameter int AW    = 11,
    parameter int WIDTH = 39
);
    // Both channels are strict valid/ready: a beat transfers on a rising clock
    // edge where VALID and READY are both high; VALID and its payload stay
    // stable until that edge, and READY never waits for VALID.
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_WE;
    logic [AW-1:0]    REQ_ADDR;
    logic [WIDTH-1:0] REQ_WDATA;
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [WIDTH-1:0] RSP_RDATA;

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_RDATA
    );

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_RDATA
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Small circular response FIFO; the caller guarantees no push when full and
// no pop when empty.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 39
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator for a single-port fakeram45 macro: fills the array after reset,
// then serves valid/ready requests with credit-managed read responses.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int               DEPTH      = 2048,
    parameter int               WIDTH      = 39,
    parameter int               RSP_DEPTH  = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    sram_port_ctrl_if.slave          bus,
    output logic                     INIT_DONE,
    output logic [$clog2(DEPTH)-1:0] RAM_ADR,
    output logic [WIDTH-1:0]         RAM_D,
    output logic                     RAM_WE,
    input  logic [WIDTH-1:0]         RAM_Q,
    output ctrl_dbg_t                dbg
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CRW = $clog2(RSP_DEPTH + 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    init_cnt_q, init_cnt_d;
    logic [AW-1:0]    ram_adr_q, ram_adr_d;
    logic [WIDTH-1:0] ram_d_q, ram_d_d;
    logic             ram_we_q, ram_we_d;
    logic [1:0]       rd_pipe_q, rd_pipe_d;
    logic [CRW-1:0]   credits_q, credits_d;

    logic             req_ready;
    logic             req_accept;
    logic             rd_accept;
    logic             rsp_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;

    // Credits count in-flight reads plus FIFO occupancy, so a read is only
    // accepted when its response already has a guaranteed slot.
    assign req_ready  = (state_q == ST_RUN) && (credits_q < CRW'(RSP_DEPTH));
    assign req_accept = bus.REQ_VALID && req_ready;
    assign rd_accept  = req_accept && !bus.REQ_WE;
    assign rsp_pop    = !fifo_empty && bus.RSP_READY;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ram_adr_d  = ram_adr_q;
        ram_d_d    = ram_d_q;
        ram_we_d   = 1'b0;
        rd_pipe_d  = {rd_pipe_q[0], 1'b0};
        credits_d  = credits_q + CRW'(rd_accept) - CRW'(rsp_pop);
        case (state_q)
            ST_INIT: begin
                // The edge after the last address is driven leaves the fill.
                if (ram_we_q && (ram_adr_q == AW'(DEPTH - 1))) begin
                    state_d = ST_RUN;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_adr_d  = init_cnt_q;
                    ram_d_d    = INIT_VALUE;
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (req_accept) begin
                    ram_adr_d    = bus.REQ_ADDR;
                    ram_d_d      = bus.REQ_WDATA;
                    ram_we_d     = bus.REQ_WE;
                    rd_pipe_d[0] = !bus.REQ_WE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ram_adr_q  <= '0;
            ram_d_q    <= '0;
            ram_we_q   <= 1'b0;
            rd_pipe_q  <= '0;
            credits_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ram_adr_q  <= ram_adr_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
            rd_pipe_q  <= rd_pipe_d;
            credits_q  <= credits_d;
        end
    end

    // rd_pipe_q[1] marks the cycle in which RAM_Q holds the read word.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (WIDTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (rd_pipe_q[1]),
        .push_data (RAM_Q),
        .pop       (rsp_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = !fifo_empty;
    assign bus.RSP_RDATA = fifo_data;

    assign INIT_DONE = (state_q == ST_RUN);
    assign RAM_ADR   = ram_adr_q;
    assign RAM_D     = ram_d_q;
    assign RAM_WE    = ram_we_q;

    assign dbg.state     = state_q;
    assign dbg.rsp_full  = fifo_full;
    assign dbg.rsp_empty = fifo_empty;

endmodule
